// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter between the pipeline WB path and the mul/div completion path.
// Optional grant/stall statistics counters are enabled with the WB_ARB_STATS_EN macro.
module wb_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int XLEN         = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pipe_valid_i,
    input  logic            pipe_wen_i,
    input  logic [4:0]      pipe_rd_i,
    input  logic [XLEN-1:0] pipe_wdata_i,
    output logic            pipe_stall_o,
    input  logic            md_valid_i,
    input  logic [4:0]      md_rd_i,
    input  logic [XLEN-1:0] md_wdata_i,
    output logic            md_ready_o,
    output logic            rf_wen_o,
    output logic [4:0]      rf_rd_o,
    output logic [XLEN-1:0] rf_wdata_o
`ifdef WB_ARB_STATS_EN
    ,
    output logic [31:0]     stat_pipe_wr_o,
    output logic [31:0]     stat_md_wr_o,
    output logic [31:0]     stat_stall_o
`endif
);

    typedef enum logic {
        PIPE_PRI = 1'b0,
        MD_FORCE = 1'b1
    } state_e;

    localparam logic [4:0] LIMIT_C = 5'(STARVE_LIMIT);

    // x0 is hardwired zero, so a slot targeting it never raises the write enable
    function automatic logic rd_writable(input logic [4:0] rd);
        rd_writable = (rd != 5'd0);
    endfunction

    state_e            state_q, state_d;
    logic [3:0]        starve_q, starve_d;
    logic              rf_wen_q, rf_wen_d;
    logic [4:0]        rf_rd_q, rf_rd_d;
    logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;

    logic              md_grant_raw_s;
    logic              md_grant_s;
    logic              pipe_grant_s;
    logic [4:0]        starve_inc_s;
    logic              limit_hit_s;

    // Grant selection: pipeline wins unless the mul/div path has been starved into MD_FORCE
    always_comb begin
        md_grant_raw_s = 1'b0;
        case (state_q)
            PIPE_PRI: md_grant_raw_s = md_valid_i & ~pipe_valid_i;
            MD_FORCE: md_grant_raw_s = md_valid_i;
            default:  md_grant_raw_s = 1'b0;
        endcase
    end

    // Handshakes are forced low while reset is asserted so no result is accepted
    assign md_grant_s   = md_grant_raw_s & rst_n;
    assign pipe_grant_s = pipe_valid_i & ~md_grant_s;
    assign md_ready_o   = md_grant_s;
    assign pipe_stall_o = pipe_valid_i & md_grant_s;

    assign starve_inc_s = {1'b0, starve_q} + 5'd1;
    assign limit_hit_s  = (starve_inc_s >= LIMIT_C);

    // Starvation counter and FSM next state
    always_comb begin
        starve_d = starve_q;
        state_d  = state_q;
        if (md_grant_s || !md_valid_i) begin
            starve_d = 4'd0;
        end else if (starve_q != 4'd15) begin
            starve_d = starve_q + 4'd1;
        end else begin
            starve_d = starve_q;
        end
        case (state_q)
            PIPE_PRI: begin
                if (md_valid_i && !md_grant_s && limit_hit_s) begin
                    state_d = MD_FORCE;
                end else begin
                    state_d = PIPE_PRI;
                end
            end
            MD_FORCE: begin
                if (md_grant_s || !md_valid_i) begin
                    state_d = PIPE_PRI;
                end else begin
                    state_d = MD_FORCE;
                end
            end
            default: state_d = PIPE_PRI;
        endcase
    end

    // Write-port next values; address and data hold when nothing is granted
    always_comb begin
        rf_wen_d   = 1'b0;
        rf_rd_d    = rf_rd_q;
        rf_wdata_d = rf_wdata_q;
        if (md_grant_s) begin
            rf_wen_d   = rd_writable(md_rd_i);
            rf_rd_d    = md_rd_i;
            rf_wdata_d = md_wdata_i;
        end else if (pipe_grant_s) begin
            rf_wen_d   = pipe_wen_i & rd_writable(pipe_rd_i);
            rf_rd_d    = pipe_rd_i;
            rf_wdata_d = pipe_wdata_i;
        end else begin
            rf_wen_d   = 1'b0;
        end
    end

    // State, counter and registered write-port outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= PIPE_PRI;
            starve_q   <= 4'd0;
            rf_wen_q   <= 1'b0;
            rf_rd_q    <= 5'd0;
            rf_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            rf_wen_q   <= rf_wen_d;
            rf_rd_q    <= rf_rd_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign rf_wen_o   = rf_wen_q;
    assign rf_rd_o    = rf_rd_q;
    assign rf_wdata_o = rf_wdata_q;

`ifdef WB_ARB_STATS_EN
    logic [31:0] stat_pipe_q, stat_md_q, stat_stall_q;

    // Free-running event counters, wrapping modulo 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_pipe_q  <= 32'd0;
            stat_md_q    <= 32'd0;
            stat_stall_q <= 32'd0;
        end else begin
            stat_pipe_q  <= stat_pipe_q  + {31'd0, pipe_grant_s};
            stat_md_q    <= stat_md_q    + {31'd0, md_grant_s};
            stat_stall_q <= stat_stall_q + {31'd0, pipe_stall_o};
        end
    end

    assign stat_pipe_wr_o = stat_pipe_q;
    assign stat_md_wr_o   = stat_md_q;
    assign stat_stall_o   = stat_stall_q;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed-vector bench for wb_arbiter (STARVE_LIMIT=4, XLEN=64).
module tb_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        pipe_valid_i, pipe_wen_i;
    logic [4:0]  pipe_rd_i;
    logic [63:0] pipe_wdata_i;
    logic        pipe_stall_o;
    logic        md_valid_i;
    logic [4:0]  md_rd_i;
    logic [63:0] md_wdata_i;
    logic        md_ready_o;
    logic        rf_wen_o;
    logic [4:0]  rf_rd_o;
    logic [63:0] rf_wdata_o;
`ifdef WB_ARB_STATS_EN
    logic [31:0] stat_pipe_wr_o, stat_md_wr_o, stat_stall_o;
`endif

    int n_vec;
    int n_err;

    wb_arbiter #(.STARVE_LIMIT(4), .XLEN(64)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pipe_valid_i (pipe_valid_i),
        .pipe_wen_i   (pipe_wen_i),
        .pipe_rd_i    (pipe_rd_i),
        .pipe_wdata_i (pipe_wdata_i),
        .pipe_stall_o (pipe_stall_o),
        .md_valid_i   (md_valid_i),
        .md_rd_i      (md_rd_i),
        .md_wdata_i   (md_wdata_i),
        .md_ready_o   (md_ready_o),
        .rf_wen_o     (rf_wen_o),
        .rf_rd_o      (rf_rd_o),
        .rf_wdata_o   (rf_wdata_o)
`ifdef WB_ARB_STATS_EN
        ,
        .stat_pipe_wr_o (stat_pipe_wr_o),
        .stat_md_wr_o   (stat_md_wr_o),
        .stat_stall_o   (stat_stall_o)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec = n_vec + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        pipe_valid_i = 1'b0; pipe_wen_i = 1'b0; pipe_rd_i = 5'd0; pipe_wdata_i = 64'd0;
        md_valid_i = 1'b1;   md_rd_i = 5'd1;    md_wdata_i = 64'h55;

        // Reset: outputs cleared, handshakes low even with md pending
        #3;
        check_eq("rst_wen", {63'd0, rf_wen_o}, 64'd0);
        check_eq("rst_rd", {59'd0, rf_rd_o}, 64'd0);
        check_eq("rst_wdata", rf_wdata_o, 64'd0);
        check_eq("rst_md_ready", {63'd0, md_ready_o}, 64'd0);
        check_eq("rst_stall", {63'd0, pipe_stall_o}, 64'd0);
        md_valid_i = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // 1: pipe only
        pipe_valid_i = 1'b1; pipe_wen_i = 1'b1; pipe_rd_i = 5'd5; pipe_wdata_i = 64'h1234;
        #1;
        check_eq("t1_stall", {63'd0, pipe_stall_o}, 64'd0);
        step();
        pipe_valid_i = 1'b0;
        check_eq("t1_wen", {63'd0, rf_wen_o}, 64'd1);
        check_eq("t1_rd", {59'd0, rf_rd_o}, 64'd5);
        check_eq("t1_wdata", rf_wdata_o, 64'h1234);
        step();
        check_eq("t1_idle_wen", {63'd0, rf_wen_o}, 64'd0);
        check_eq("t1_hold_rd", {59'd0, rf_rd_o}, 64'd5);

        // 2: md only
        md_valid_i = 1'b1; md_rd_i = 5'd10; md_wdata_i = 64'hDEAD_BEEF;
        #1;
        check_eq("t2_ready", {63'd0, md_ready_o}, 64'd1);
        check_eq("t2_stall", {63'd0, pipe_stall_o}, 64'd0);
        step();
        md_valid_i = 1'b0;
        check_eq("t2_wen", {63'd0, rf_wen_o}, 64'd1);
        check_eq("t2_rd", {59'd0, rf_rd_o}, 64'd10);
        check_eq("t2_wdata", rf_wdata_o, 64'hDEAD_BEEF);

        // 3: starvation with continuous pipeline traffic
        pipe_valid_i = 1'b1; pipe_wen_i = 1'b1; pipe_rd_i = 5'd3; pipe_wdata_i = 64'h33;
        md_valid_i = 1'b1; md_rd_i = 5'd7; md_wdata_i = 64'h77;
        for (int c = 0; c < 4; c++) begin
            #1;
            check_eq($sformatf("t3_ready_c%0d", c), {63'd0, md_ready_o}, 64'd0);
            check_eq($sformatf("t3_stall_c%0d", c), {63'd0, pipe_stall_o}, 64'd0);
            step();
            check_eq($sformatf("t3_pipe_rd_c%0d", c), {59'd0, rf_rd_o}, 64'd3);
        end
        #1;
        check_eq("t3_ready_c4", {63'd0, md_ready_o}, 64'd1);
        check_eq("t3_stall_c4", {63'd0, pipe_stall_o}, 64'd1);
        step();
        md_valid_i = 1'b0;
        pipe_rd_i = 5'd4; pipe_wdata_i = 64'h44;
        check_eq("t3_md_wen", {63'd0, rf_wen_o}, 64'd1);
        check_eq("t3_md_rd", {59'd0, rf_rd_o}, 64'd7);
        check_eq("t3_md_wdata", rf_wdata_o, 64'h77);
        #1;
        check_eq("t3_c5_stall", {63'd0, pipe_stall_o}, 64'd0);
        step();
        pipe_valid_i = 1'b0;
        check_eq("t3_c6_rd", {59'd0, rf_rd_o}, 64'd4);
        check_eq("t3_c6_wdata", rf_wdata_o, 64'h44);

        // 4: x0 suppression and a non-writing pipeline slot
        pipe_valid_i = 1'b1; pipe_wen_i = 1'b1; pipe_rd_i = 5'd0; pipe_wdata_i = 64'hFF;
        step();
        check_eq("t4_px0_wen", {63'd0, rf_wen_o}, 64'd0);
        check_eq("t4_px0_wdata", rf_wdata_o, 64'hFF);
        pipe_wen_i = 1'b0; pipe_rd_i = 5'd9; pipe_wdata_i = 64'h99;
        step();
        pipe_valid_i = 1'b0;
        check_eq("t4_nowen_wen", {63'd0, rf_wen_o}, 64'd0);
        check_eq("t4_nowen_rd", {59'd0, rf_rd_o}, 64'd9);
        md_valid_i = 1'b1; md_rd_i = 5'd0; md_wdata_i = 64'hAB;
        #1;
        check_eq("t4_mx0_ready", {63'd0, md_ready_o}, 64'd1);
        step();
        md_valid_i = 1'b0;
        check_eq("t4_mx0_wen", {63'd0, rf_wen_o}, 64'd0);
        check_eq("t4_mx0_wdata", rf_wdata_o, 64'hAB);

        // 5: async reset while starve count is 3
        pipe_valid_i = 1'b1; pipe_wen_i = 1'b1; pipe_rd_i = 5'd3; pipe_wdata_i = 64'h33;
        md_valid_i = 1'b1; md_rd_i = 5'd7; md_wdata_i = 64'h77;
        step(); step(); step();
        check_eq("t5_pre_wen", {63'd0, rf_wen_o}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t5_rst_wen", {63'd0, rf_wen_o}, 64'd0);
        check_eq("t5_rst_ready", {63'd0, md_ready_o}, 64'd0);
        check_eq("t5_rst_stall", {63'd0, pipe_stall_o}, 64'd0);
        md_valid_i = 1'b0;
        step();
        rst_n = 1'b1;
        md_valid_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            check_eq($sformatf("t5_ready_c%0d", c), {63'd0, md_ready_o}, 64'd0);
            step();
        end
        #1;
        check_eq("t5_ready_c4", {63'd0, md_ready_o}, 64'd1);
        step();
        md_valid_i = 1'b0;
        pipe_valid_i = 1'b0;
        check_eq("t5_md_rd", {59'd0, rf_rd_o}, 64'd7);

`ifdef WB_ARB_STATS_EN
        // 6: scenario 3 for ten cycles from a fresh reset
        #2;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        pipe_valid_i = 1'b1; md_valid_i = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (md_ready_o) begin
                step();
                md_valid_i = 1'b0;
            end else begin
                step();
            end
        end
        pipe_valid_i = 1'b0;
        check_eq("t6_md_wr", {32'd0, stat_md_wr_o}, 64'd1);
        check_eq("t6_stall", {32'd0, stat_stall_o}, 64'd1);
        check_eq("t6_pipe_wr", {32'd0, stat_pipe_wr_o}, 64'd9);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
